// File: rtl/digit_scan_mux_pkg.sv
// Shared types, default constants and helpers for the digit scan multiplexer.
package digit_scan_pkg;

    // Slot phase: dead-time blanking, then the digit is driven.
    typedef enum logic {
        PH_DEAD = 1'b0,
        PH_ON   = 1'b1
    } scan_phase_t;

    localparam int DEF_REFRESH_DIV = 24000;
    localparam int DEF_BLANK_CYC   = 8;

    // Map a logical "enable asserted" onto the physical pin level.
    function automatic logic en_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/digit_scan_mux_slot_timer.sv
// Slot timer: counts the cycles of one digit slot, splits the slot into a
// dead phase and an on phase, and flags the last cycle of the slot.
module slot_timer
    import digit_scan_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
    input  logic        clk,
    input  logic        rst,
    output scan_phase_t phase_nxt,
    output logic        slot_end
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    // With no dead time the slot is on from its first cycle.
    localparam scan_phase_t PH_START = (BLANK_CYC == 0) ? PH_ON : PH_DEAD;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    scan_phase_t      phase_r;
    scan_phase_t      phase_nxt_s;

    // Next slot count and phase.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        phase_nxt_s = phase_r;
        case (phase_r)
            PH_DEAD: begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (cnt_r == BLANK_LAST) begin
                    phase_nxt_s = PH_ON;
                end else begin
                    phase_nxt_s = PH_DEAD;
                end
            end
            PH_ON: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = '0;
                    phase_nxt_s = PH_START;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    phase_nxt_s = PH_ON;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                phase_nxt_s = PH_START;
            end
        endcase
    end

    // Slot counter and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            phase_r <= PH_START;
        end else begin
            cnt_r   <= cnt_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

    assign phase_nxt = phase_nxt_s;
    assign slot_end  = (phase_r == PH_ON) && (cnt_r == CNT_LAST);

endmodule

// File: rtl/digit_scan_mux.sv
// Digit scan multiplexer: time-shares NUM_DIGITS data words onto one segment
// bus, with dead-time blanking, per-digit masking and a frame marker.
module digit_scan_mux
    import digit_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int DATA_W        = 4,
    parameter int REFRESH_DIV   = DEF_REFRESH_DIV,
    parameter int BLANK_CYC     = DEF_BLANK_CYC,
    parameter bit EN_ACTIVE_LOW = 1'b0
) (
    input  logic                          Osc,
    input  logic                          reset,
    input  logic [NUM_DIGITS*DATA_W-1:0]  digits_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [DATA_W-1:0]             s,
    output logic [NUM_DIGITS-1:0]         en,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_IDLE = {NUM_DIGITS{en_level(1'b0, EN_ACTIVE_LOW)}};

    if (NUM_DIGITS < 2) begin : g_bad_num_digits
        $error("digit_scan_mux: NUM_DIGITS must be at least 2");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("digit_scan_mux: REFRESH_DIV must be at least 2");
    end
    if (BLANK_CYC >= REFRESH_DIV) begin : g_bad_blank_cyc
        $error("digit_scan_mux: BLANK_CYC must be less than REFRESH_DIV");
    end

    scan_phase_t            phase_nxt_s;
    logic                   slot_end_s;
    logic                   wrap_s;
    logic [IDX_W-1:0]       digit_idx_r;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [NUM_DIGITS-1:0]  en_r;
    logic [NUM_DIGITS-1:0]  en_nxt_s;
    logic                   frame_tick_r;

    slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_slot_timer (
        .clk       (Osc),
        .rst       (reset),
        .phase_nxt (phase_nxt_s),
        .slot_end  (slot_end_s)
    );

    assign wrap_s = slot_end_s && (digit_idx_r == IDX_LAST);

    // Next digit index; explicit wrap keeps non-power-of-2 counts legal.
    always_comb begin
        idx_nxt_s = digit_idx_r;
        if (slot_end_s) begin
            if (digit_idx_r == IDX_LAST) begin
                idx_nxt_s = '0;
            end else begin
                idx_nxt_s = digit_idx_r + IDX_W'(1);
            end
        end else begin
            idx_nxt_s = digit_idx_r;
        end
    end

    // Enable decode from next-state values so en lines up with phase/index.
    always_comb begin
        en_nxt_s = EN_IDLE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            en_nxt_s[i] = en_level((phase_nxt_s == PH_ON) &&
                                   (idx_nxt_s == IDX_W'(i)) &&
                                   !blank_mask[i], EN_ACTIVE_LOW);
        end
    end

    // Digit index, enable and frame marker registers.
    always_ff @(posedge Osc or posedge reset) begin
        if (reset) begin
            digit_idx_r  <= '0;
            en_r         <= EN_IDLE;
            frame_tick_r <= 1'b0;
        end else begin
            digit_idx_r  <= idx_nxt_s;
            en_r         <= en_nxt_s;
            frame_tick_r <= wrap_s;
        end
    end

    assign s          = digits_in[32'(digit_idx_r) * DATA_W +: DATA_W];
    assign en         = en_r;
    assign digit_idx  = digit_idx_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux: a 4-digit blanked instance plus two 2-digit
// legacy instances (active-high and active-low) share clock and reset.
module tb_digit_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;

    logic [3:0]  s;
    logic [3:0]  en;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    logic [3:0]  s_l0, s_l1;
    logic [1:0]  en_l0, en_l1;
    logic        idx_l0, idx_l1;
    logic        ft_l0, ft_l1;

    always #5 clk = ~clk;

    digit_scan_mux #(
        .NUM_DIGITS(4), .DATA_W(4), .REFRESH_DIV(10), .BLANK_CYC(2), .EN_ACTIVE_LOW(1'b0)
    ) dut (
        .Osc(clk), .reset(rst), .digits_in(digits_in), .blank_mask(blank_mask),
        .s(s), .en(en), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    digit_scan_mux #(
        .NUM_DIGITS(2), .DATA_W(4), .REFRESH_DIV(8), .BLANK_CYC(0), .EN_ACTIVE_LOW(1'b0)
    ) dut_leg (
        .Osc(clk), .reset(rst), .digits_in(digits_in[7:0]), .blank_mask(2'b00),
        .s(s_l0), .en(en_l0), .digit_idx(idx_l0), .frame_tick(ft_l0)
    );

    digit_scan_mux #(
        .NUM_DIGITS(2), .DATA_W(4), .REFRESH_DIV(8), .BLANK_CYC(0), .EN_ACTIVE_LOW(1'b1)
    ) dut_leg_al (
        .Osc(clk), .reset(rst), .digits_in(digits_in[7:0]), .blank_mask(2'b00),
        .s(s_l1), .en(en_l1), .digit_idx(idx_l1), .frame_tick(ft_l1)
    );

    typedef struct {
        logic [1:0] idx;
        logic [3:0] en;
        logic       ft;
        logic       lidx;
        logic [1:0] len;
        logic       lft;
        int         t;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   t_model  = 0;
    bit   duty_en;

    int         cyc = 0;
    int         last_ft = 0;
    bit         have_prev = 1'b0;
    int         on_cnt[4];
    int         hi0 = 0, hi1 = 0;
    bit         seen0 = 1'b0;
    logic [1:0] prev_idx = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Closed-form reference: t = rising edges since reset was last sampled high.
    function automatic exp_t model(input int t, input logic [3:0] mask);
        exp_t e;
        int   pos;
        e.t   = t;
        e.idx = 2'((t / 10) % 4);
        pos   = t % 10;
        if (t > 0 && pos >= 2) e.en = 4'(4'b0001 << e.idx) & ~mask;
        else                   e.en = 4'b0000;
        e.ft   = (t > 0) && (t % 40 == 0);
        e.lidx = 1'((t / 8) % 2);
        e.len  = (t > 0) ? 2'(2'b01 << e.lidx) : 2'b00;
        e.lft  = (t > 0) && (t % 16 == 0);
        return e;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        logic [15:0] sh;
        sh = v >> (4 * i);
        return sh[3:0];
    endfunction

    task automatic cycle_checks();
        exp_t       e;
        logic [1:0] inv_len;
        logic [1:0] inv_l0;
        cyc++;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            inv_len = ~e.len;
            inv_l0  = ~en_l0;
            check("idx",    32'(digit_idx),  32'(e.idx));
            check("en",     32'(en),         32'(e.en));
            check("ft",     32'(frame_tick), 32'(e.ft));
            check("s",      32'(s),          32'(nib(digits_in, int'(e.idx))));
            check("l_idx",  32'(idx_l0),     32'(e.lidx));
            check("l_en",   32'(en_l0),      32'(e.len));
            check("l_ft",   32'(ft_l0),      32'(e.lft));
            check("l_s",    32'(s_l0),       32'(nib(digits_in, int'(e.lidx))));
            check("al_idx", 32'(idx_l1),     32'(e.lidx));
            check("al_en",  32'(en_l1),      32'(inv_len));
            check("al_ft",  32'(ft_l1),      32'(e.lft));
            check("al_s",   32'(s_l1),       32'(nib(digits_in, int'(e.lidx))));
            if (e.t > 0) begin
                check("l_compl", 32'(en_l0[0]), 32'(!en_l0[1]));
                check("al_inv",  32'(en_l1),    32'(inv_l0));
            end
        end
        check("onehot", 32'($countones(en) <= 1), 32'd1);
        if (digit_idx != prev_idx) check("dead_chg", 32'(en), 32'd0);
        prev_idx = digit_idx;
        if (frame_tick && duty_en) begin
            if (have_prev) begin
                check("frame_len", 32'(cyc - last_ft), 32'd40);
                for (int i = 0; i < 4; i++) check("duty", 32'(on_cnt[i]), 32'd8);
            end
            have_prev = 1'b1;
            last_ft   = cyc;
            for (int i = 0; i < 4; i++) on_cnt[i] = 0;
        end
        for (int i = 0; i < 4; i++) if (en[i]) on_cnt[i]++;
        if (rst) begin
            hi0 = 0; hi1 = 0; seen0 = 1'b0;
        end else begin
            if (en_l0[1]) hi1++;
            else if (hi1 != 0) begin
                check("l_hi1", 32'(hi1), 32'd8);
                hi1 = 0;
            end
            if (en_l0[0]) hi0++;
            else if (hi0 != 0) begin
                if (seen0) check("l_hi0", 32'(hi0), 32'd8);
                seen0 = 1'b1;
                hi0 = 0;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        digits_in  = 16'hDCBA;
        blank_mask = 4'b0000;
        duty_en    = 1'b1;
        for (int i = 0; i < 4; i++) on_cnt[i] = 0;
        fork
            forever begin
                @(posedge clk);
                if (rst) t_model = 0;
                else     t_model++;
                sb_q.push_back(model(t_model, blank_mask));
            end
            forever begin
                @(negedge clk);
                cycle_checks();
            end
            begin
                step(5);
                check("rst_al_en", 32'(en_l1), 32'd3);
                rst = 1'b0;
                step(5);
                check("scan_a", 32'(s), 32'hA);
                check("slot0_en", 32'(en), 32'd1);
                step(10);
                check("scan_b", 32'(s), 32'hB);
                step(10);
                check("scan_c", 32'(s), 32'hC);
                step(10);
                check("scan_d", 32'(s), 32'hD);
                step(90);
                duty_en    = 1'b0;
                blank_mask = 4'b0100;
                step(45);
                for (int k = 0; k < 60; k++) begin
                    if (digit_idx == 2'd2) break;
                    step(1);
                end
                check("reach_idx2", 32'(digit_idx), 32'd2);
                step(3);
                check("blank_en2", 32'(en[2]), 32'd0);
                check("blank_idx", 32'(digit_idx), 32'd2);
                blank_mask = 4'b0000;
                step(1);
                check("unblank", 32'(en), 32'b0100);
                step(2);
                rst = 1'b1;
                #1;
                check("arst_en", 32'(en), 32'd0);
                check("arst_idx", 32'(digit_idx), 32'd0);
                check("arst_al", 32'(en_l1), 32'd3);
                step(3);
                rst = 1'b0;
                step(1);
                check("post_dead", 32'(en), 32'd0);
                step(1);
                check("post_on", 32'(en), 32'd1);
                digits_in = 16'h1234;
                #1;
                check("s_follow", 32'(s), 32'h4);
                step(40);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
